// File: rtl/dead_time_monitor.sv
// Dead-time and shoot-through monitor for the two legs of a full bridge.
// Optional macro DT_MONITOR_GATE_BLOCK_EN forces o_gate off while o_fault is high.
module dead_time_monitor (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic [3:0] i_gate,
  input  logic [9:0] i_min_deadtime,
  input  logic       i_clear,
  output logic [9:0] o_deadtime_a,
  output logic [9:0] o_deadtime_b,
  output logic [1:0] o_valid,
  output logic [1:0] o_violation,
  output logic [1:0] o_shoot_through,
  output logic       o_fault,
  output logic [3:0] o_gate
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_DEAD = 2'd2
  } state_t;

  localparam logic [9:0] CNT_MAX = 10'h3FF;

  logic [3:0]       g_q;
  state_t [1:0]     state_q, state_d;
  logic [1:0][9:0]  cnt_q, cnt_d;
  logic [1:0]       last_lo_q, last_lo_d;
  logic [1:0][9:0]  dt_q, dt_d;
  logic [1:0]       valid_q, valid_d;
  logic [1:0]       viol_q, viol_d;
  logic [1:0]       shoot_q, shoot_d;

  logic [1:0]       leg_hi, leg_lo;
  logic [1:0]       on_now, other_now;
  logic [1:0]       meas, shoot_ev, viol_ev;
  logic [1:0][9:0]  meas_val;

  // last_lo selects which switch of the leg counts as "on" vs "complementary".
  assign leg_hi    = {g_q[2], g_q[0]};
  assign leg_lo    = {g_q[3], g_q[1]};
  assign on_now    = (leg_hi & ~last_lo_q) | (leg_lo & last_lo_q);
  assign other_now = (leg_lo & ~last_lo_q) | (leg_hi & last_lo_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_lo_d = last_lo_q;
    dt_d      = dt_q;
    valid_d   = '0;
    meas      = '0;
    meas_val  = '0;
    shoot_ev  = '0;
    viol_ev   = '0;
    viol_d    = viol_q;
    shoot_d   = shoot_q;

    for (int l = 0; l < 2; l++) begin
      case (state_q[l])
        S_IDLE: begin
          if (leg_hi[l] && leg_lo[l]) begin
            shoot_ev[l] = 1'b1;
          end else if (leg_hi[l] || leg_lo[l]) begin
            last_lo_d[l] = leg_lo[l];
            state_d[l]   = S_ON;
          end
        end
        S_ON: begin
          if (leg_hi[l] && leg_lo[l]) begin
            shoot_ev[l] = 1'b1;
          end else if (!on_now[l] && other_now[l]) begin
            meas[l]      = 1'b1;
            meas_val[l]  = 10'd0;
            last_lo_d[l] = ~last_lo_q[l];
          end else if (!on_now[l]) begin
            state_d[l] = S_DEAD;
            cnt_d[l]   = 10'd1;
          end
        end
        S_DEAD: begin
          if (leg_hi[l] && leg_lo[l]) begin
            shoot_ev[l] = 1'b1;
            state_d[l]  = S_IDLE;
          end else if (other_now[l]) begin
            meas[l]      = 1'b1;
            meas_val[l]  = cnt_q[l];
            last_lo_d[l] = ~last_lo_q[l];
            state_d[l]   = S_ON;
          end else if (on_now[l]) begin
            state_d[l] = S_ON;
          end else if (cnt_q[l] != CNT_MAX) begin
            cnt_d[l] = cnt_q[l] + 10'd1;
          end
        end
        default: begin
          state_d[l] = S_IDLE;
        end
      endcase
    end

    // A new event in the same cycle as i_clear still sets the sticky flag.
    for (int l = 0; l < 2; l++) begin
      if (meas[l]) begin
        dt_d[l]    = meas_val[l];
        valid_d[l] = 1'b1;
        viol_ev[l] = (meas_val[l] < i_min_deadtime);
      end
      viol_d[l]  = (viol_q[l] & ~i_clear) | viol_ev[l];
      shoot_d[l] = (shoot_q[l] & ~i_clear) | shoot_ev[l];
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      g_q       <= 4'b0000;
      cnt_q     <= '0;
      last_lo_q <= '0;
      dt_q      <= '0;
      valid_q   <= '0;
      viol_q    <= '0;
      shoot_q   <= '0;
      for (int l = 0; l < 2; l++) begin
        state_q[l] <= S_IDLE;
      end
    end else begin
      g_q       <= i_gate;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_lo_q <= last_lo_d;
      dt_q      <= dt_d;
      valid_q   <= valid_d;
      viol_q    <= viol_d;
      shoot_q   <= shoot_d;
    end
  end

  assign o_deadtime_a    = dt_q[0];
  assign o_deadtime_b    = dt_q[1];
  assign o_valid         = valid_q;
  assign o_violation     = viol_q;
  assign o_shoot_through = shoot_q;
  assign o_fault         = (|viol_q) | (|shoot_q);

`ifdef DT_MONITOR_GATE_BLOCK_EN
  assign o_gate = g_q & {4{~o_fault}};
`else
  assign o_gate = g_q;
`endif

endmodule
